// File: rtl/mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : mac_seq
// Description : Dot-product sequencer for a pipelined signed 16x16 MAC.
//               Takes a job length, pulls signed operand pairs over a
//               valid/ready stream and issues them to the MAC as a
//               clear-then-accumulate instruction sequence. It then waits out
//               the MAC pipeline and captures the result and guard bits,
//               which it presents on a valid/ready output port.
// Ports       : clk, reset_n             clock, async active-low reset
//               start, len               job request and pair count
//               op_valid/op_ready        operand stream handshake
//               op_a, op_b               signed operand pair
//               instruction              3'b000 clear+mul, 3'b001 mul-acc
//               multiplier, multiplicand operands to the MAC
//               stall                    1 = MAC ignores current operands
//               mac_result, mac_protect  MAC result and guard bits
//               dot_valid/dot_ready      result handshake
//               dot_result, dot_protect  captured result and guard bits
//               busy                     sequencer is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module mac_seq #(
  parameter int LATENCY = 4,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic [2:0]       instruction,
  output logic [15:0]      multiplier,
  output logic [15:0]      multiplicand,
  output logic             stall,
  input  logic [31:0]      mac_result,
  input  logic [7:0]       mac_protect,
  output logic             dot_valid,
  input  logic             dot_ready,
  output logic [31:0]      dot_result,
  output logic [7:0]       dot_protect,
  output logic             busy
);

  localparam int DRAIN_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_ISSUE = 2'd1;
  localparam logic [1:0] C_DRAIN = 2'd2;
  localparam logic [1:0] C_HOLD  = 2'd3;

  localparam logic [2:0] C_INSTR_CLR = 3'b000;
  localparam logic [2:0] C_INSTR_ACC = 3'b001;

  logic [1:0]         r_state;
  logic [LEN_W-1:0]   r_remaining;
  logic [DRAIN_W-1:0] r_drain;
  logic               r_first;
  logic [2:0]         r_instruction;
  logic [15:0]        r_multiplier;
  logic [15:0]        r_multiplicand;
  logic               r_stall;
  logic               r_dot_valid;
  logic [31:0]        r_dot_result;
  logic [7:0]         r_dot_protect;

  logic               w_accept;

  assign w_accept = (r_state == C_ISSUE) && op_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= C_IDLE;
      r_remaining    <= '0;
      r_drain        <= '0;
      r_first        <= 1'b0;
      r_instruction  <= C_INSTR_CLR;
      r_multiplier   <= '0;
      r_multiplicand <= '0;
      r_stall        <= 1'b1;
      r_dot_valid    <= 1'b0;
      r_dot_result   <= '0;
      r_dot_protect  <= '0;
    end else begin
      case (r_state)
        C_IDLE: begin
          if (start) begin
            if (len != '0) begin
              r_remaining <= len;
              r_first     <= 1'b1;
              r_state     <= C_ISSUE;
            end else begin
              // Empty job: report a zero result without touching the MAC.
              r_dot_result  <= '0;
              r_dot_protect <= '0;
              r_state       <= C_HOLD;
            end
          end
        end

        C_ISSUE: begin
          if (w_accept) begin
            r_multiplier   <= op_a;
            r_multiplicand <= op_b;
            r_stall        <= 1'b0;
            r_instruction  <= r_first ? C_INSTR_CLR : C_INSTR_ACC;
            r_first        <= 1'b0;
            r_remaining    <= r_remaining - 1'b1;
            if (r_remaining == LEN_W'(1)) begin
              r_drain <= DRAIN_W'(LATENCY);
              r_state <= C_DRAIN;
            end
          end else begin
            // Bubble: operands and instruction hold, MAC told to ignore them.
            r_stall <= 1'b1;
          end
        end

        C_DRAIN: begin
          r_stall <= 1'b1;
          // The drain count runs LATENCY+1 cycles so the capture lines up
          // with the cycle the last pair's result leaves the MAC pipeline.
          if (r_drain == '0) begin
            r_dot_result  <= mac_result;
            r_dot_protect <= mac_protect;
            r_dot_valid   <= 1'b1;
            r_state       <= C_HOLD;
          end else begin
            r_drain <= r_drain - 1'b1;
          end
        end

        C_HOLD: begin
          if (r_dot_valid && dot_ready) begin
            r_dot_valid <= 1'b0;
            r_state     <= C_IDLE;
          end else begin
            // The empty-job path enters HOLD with dot_valid low; raise it here.
            r_dot_valid <= 1'b1;
          end
        end

        default: begin
          r_state <= C_IDLE;
        end
      endcase
    end
  end

  assign op_ready     = (r_state == C_ISSUE);
  assign busy         = (r_state != C_IDLE);
  assign instruction  = r_instruction;
  assign multiplier   = r_multiplier;
  assign multiplicand = r_multiplicand;
  assign stall        = r_stall;
  assign dot_valid    = r_dot_valid;
  assign dot_result   = r_dot_result;
  assign dot_protect  = r_dot_protect;

endmodule
`default_nettype wire

// File: tb/tb_mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_seq
// Description : Self-checking bench for mac_seq. A small behavioural MAC with
//               a 4-cycle pipeline and 40-bit accumulator answers the
//               sequencer; jobs come from a vector table with hand-computed
//               results, plus directed sequences for backpressure, empty
//               jobs and reset in the middle of a job.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_seq;

  localparam int LATENCY = 4;
  localparam int LEN_W   = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             op_valid;
  logic             op_ready;
  logic [15:0]      op_a;
  logic [15:0]      op_b;
  logic [2:0]       instruction;
  logic [15:0]      multiplier;
  logic [15:0]      multiplicand;
  logic             stall;
  logic [31:0]      mac_result;
  logic [7:0]       mac_protect;
  logic             dot_valid;
  logic             dot_ready;
  logic [31:0]      dot_result;
  logic [7:0]       dot_protect;
  logic             busy;

  mac_seq #(.LATENCY(LATENCY), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .instruction(instruction), .multiplier(multiplier),
    .multiplicand(multiplicand), .stall(stall),
    .mac_result(mac_result), .mac_protect(mac_protect),
    .dot_valid(dot_valid), .dot_ready(dot_ready),
    .dot_result(dot_result), .dot_protect(dot_protect), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural MAC: operands seen at an edge produce a result visible
  // LATENCY cycles after the cycle they were presented in.
  logic signed [39:0] m_acc;
  logic signed [39:0] m_nxt;
  logic [39:0]        m_d0, m_d1, m_d2, m_d3;

  always_comb begin
    m_nxt = ((instruction == 3'b000) ? 40'sd0 : m_acc)
          + 40'($signed(multiplier) * $signed(multiplicand));
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_acc <= '0; m_d0 <= '0; m_d1 <= '0; m_d2 <= '0; m_d3 <= '0;
    end else begin
      if (!stall) m_acc <= m_nxt;
      m_d0 <= stall ? m_acc : m_nxt;
      m_d1 <= m_d0;
      m_d2 <= m_d1;
      m_d3 <= m_d2;
    end
  end

  assign mac_result  = m_d3[31:0];
  assign mac_protect = m_d3[39:32];

  typedef struct packed {
    logic [7:0]       len;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [3:0]       gap;
    logic [31:0]      res;
    logic [7:0]       prot;
  } vec_t;

  vec_t vecs [6];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int l, input int a0, input int b0, input int a1,
                              input int b1, input int a2, input int b2, input int a3,
                              input int b3, input int gap, input logic [31:0] res,
                              input logic [7:0] prot);
    vec_t v;
    v.len = 8'(l);
    v.a[0] = 16'(a0); v.b[0] = 16'(b0);
    v.a[1] = 16'(a1); v.b[1] = 16'(b1);
    v.a[2] = 16'(a2); v.b[2] = 16'(b2);
    v.a[3] = 16'(a3); v.b[3] = 16'(b3);
    v.gap = 4'(gap);
    v.res = res;
    v.prot = prot;
    return v;
  endfunction

  // Runs one job from an idle DUT; hold>0 withholds dot_ready for that many
  // cycles while pulsing start, which must be ignored.
  task automatic run_job(input vec_t v, input int hold, input string tag);
    int waited;
    logic [31:0] held;
    start = 1'b1; len = v.len; dot_ready = (hold == 0);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy"}, 40'(busy), 40'd1);
    check({tag, " op_ready"}, 40'(op_ready), 40'd1);
    for (int i = 0; i < int'(v.len); i++) begin
      if (i == 1 && v.gap != 0) begin
        op_valid = 1'b0;
        for (int g = 0; g < int'(v.gap); g++) begin
          @(posedge clk); #1;
          check({tag, " gap stall"}, 40'(stall), 40'd1);
          check({tag, " gap instr held"}, 40'(instruction), 40'd0);
          check({tag, " gap mult held"}, 40'(multiplier), 40'(v.a[0]));
        end
      end
      op_valid = 1'b1; op_a = v.a[i]; op_b = v.b[i];
      @(posedge clk); #1;
      op_valid = 1'b0;
      check({tag, " instr"}, 40'(instruction), (i == 0) ? 40'd0 : 40'd1);
      check({tag, " stall"}, 40'(stall), 40'd0);
      check({tag, " multiplier"}, 40'(multiplier), 40'(v.a[i]));
      check({tag, " multiplicand"}, 40'(multiplicand), 40'(v.b[i]));
    end
    check({tag, " op_ready after last"}, 40'(op_ready), 40'd0);
    waited = 0;
    while (!dot_valid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
      if (!dot_valid) check({tag, " drain stall"}, 40'(stall), 40'd1);
    end
    check({tag, " result latency"}, 40'(waited), 40'(LATENCY + 1));
    check({tag, " dot_result"}, 40'(dot_result), 40'(v.res));
    check({tag, " dot_protect"}, 40'(dot_protect), 40'(v.prot));
    held = dot_result;
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        start = (h == 1); len = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " hold valid"}, 40'(dot_valid), 40'd1);
        check({tag, " hold result"}, 40'(dot_result), 40'(held));
        check({tag, " hold busy"}, 40'(busy), 40'd1);
      end
      // Handshake cycle: a start here must also be ignored.
      dot_ready = 1'b1; start = 1'b1; len = 8'd1;
      @(posedge clk); #1;
      start = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    check({tag, " valid after hs"}, 40'(dot_valid), 40'd0);
    check({tag, " busy after hs"}, 40'(busy), 40'd0);
  endtask

  initial begin
    int seen;
    reset_n = 1'b0; start = 1'b0; len = '0; op_valid = 1'b0;
    op_a = '0; op_b = '0; dot_ready = 1'b0;

    vecs[0] = mk(3, 2, 3, 4, 5, -1, 7, 0, 0, 0, 32'd19, 8'h00);
    vecs[1] = mk(3, 2, 3, 4, 5, -1, 7, 0, 0, 2, 32'd19, 8'h00);
    vecs[2] = mk(2, -32768, -32768, -32768, -32768, 0, 0, 0, 0, 0, 32'h8000_0000, 8'h00);
    vecs[3] = mk(1, -5, 6, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFE2, 8'hFF);
    vecs[4] = mk(4, 100, 200, -300, 400, 32767, 32767, 1, -1, 1, 32'h3FFD_7960, 8'h00);
    vecs[5] = mk(1, 3, 4, 0, 0, 0, 0, 0, 0, 0, 32'd12, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    check("reset instr", 40'(instruction), 40'd0);
    check("reset multiplier", 40'(multiplier), 40'd0);
    check("reset multiplicand", 40'(multiplicand), 40'd0);
    check("reset stall", 40'(stall), 40'd1);
    check("reset dot_valid", 40'(dot_valid), 40'd0);
    check("reset dot_result", 40'(dot_result), 40'd0);
    check("reset busy", 40'(busy), 40'd0);
    check("reset op_ready", 40'(op_ready), 40'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 5; k++) begin
      run_job(vecs[k], 0, $sformatf("vec%0d", k));
      @(posedge clk); #1;
    end

    // Backpressure with ignored start pulses.
    run_job(vecs[5], 5, "backpressure");
    @(posedge clk); #1;

    // Empty job right after a non-zero result.
    dot_ready = 1'b1; start = 1'b1; len = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("len0 busy", 40'(busy), 40'd1);
    check("len0 op_ready", 40'(op_ready), 40'd0);
    check("len0 early valid", 40'(dot_valid), 40'd0);
    @(posedge clk); #1;
    check("len0 valid", 40'(dot_valid), 40'd1);
    check("len0 result", 40'(dot_result), 40'd0);
    check("len0 protect", 40'(dot_protect), 40'd0);
    check("len0 stall", 40'(stall), 40'd1);
    @(posedge clk); #1;
    check("len0 valid after hs", 40'(dot_valid), 40'd0);
    check("len0 busy after hs", 40'(busy), 40'd0);
    @(posedge clk); #1;

    // Reset after the first of three pairs.
    start = 1'b1; len = 8'd3;
    @(posedge clk); #1;
    start = 1'b0; op_valid = 1'b1; op_a = 16'd5; op_b = 16'd5;
    @(posedge clk); #1;
    check("pre-reset stall", 40'(stall), 40'd0);
    op_a = 16'd6; op_b = 16'd6;
    #2 reset_n = 1'b0;
    #1;
    check("mid reset busy", 40'(busy), 40'd0);
    check("mid reset op_ready", 40'(op_ready), 40'd0);
    check("mid reset stall", 40'(stall), 40'd1);
    check("mid reset multiplier", 40'(multiplier), 40'd0);
    check("mid reset instr", 40'(instruction), 40'd0);
    op_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (dot_valid || busy) seen++;
    end
    check("no result after reset", 40'(seen), 40'd0);
    run_job(mk(1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 32'd9, 8'h00), 0, "post-reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_seq.md
# mac_seq

Dot-product sequencer that drives the pipelined signed 16x16 MAC from the operand side. It accepts a job length, pulls signed operand pairs over a valid/ready stream, and issues them to the MAC as a clear-then-accumulate instruction sequence. It waits out the MAC pipeline latency, then captures the MAC's 32-bit result and 8-bit protect (guard) bits and presents them on an output valid/ready port.

## Interface
- LATENCY, 4: cycles from operands presented on the MAC ports to the matching mac_result/mac_protect.
- LEN_W, 8: width of the job length.
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs, latched with start.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  sequencer accepts a pair.
- op_a, op_b  in  16  signed operand pair.
- instruction  out  3  MAC instruction: 3'b000 = multiply and clear the accumulator; 3'b001 = multiply-accumulate.
- multiplier, multiplicand  out  16  signed operands to the MAC.
- stall  out  1  1 = MAC ignores the current operands.
- mac_result  in  32  MAC result.
- mac_protect  in  8  MAC guard bits.
- dot_valid  out  1  dot result valid.
- dot_ready  in  1  consumer accepts the result.
- dot_result  out  32  captured result.
- dot_protect  out  8  captured guard bits.
- busy  out  1  state is not IDLE.

## Operation
- All outputs are registered, except op_ready = (state==ISSUE) and busy = (state!=IDLE).
- FSM states: IDLE, ISSUE, DRAIN, HOLD.
- IDLE:
  - start=1 and len!=0: latch len into the remaining counter, set first=1, go to ISSUE.
  - start=1 and len==0: load dot_result=0 and dot_protect=0, go to HOLD.
  - start=0: stay in IDLE.
- ISSUE, handshake op_valid & op_ready:
  - Register op_a into multiplier and op_b into multiplicand, set stall=0.
  - instruction = 3'b000 if first, else 3'b001; clear first.
  - Decrement remaining. If remaining was 1, go to DRAIN and load the drain counter with LATENCY.
- ISSUE with op_valid=0: stall=1; instruction and operands hold their previous values.
- DRAIN:
  - stall=1 every cycle.
  - Decrement the drain counter each cycle.
  - In the cycle the counter reads 0: capture mac_result into dot_result and mac_protect into dot_protect, set dot_valid=1, go to HOLD.
- HOLD:
  - dot_valid, dot_result and dot_protect are stable until dot_valid & dot_ready.
  - On that handshake: dot_valid=0 and go to IDLE.
- start is ignored outside IDLE, including in the HOLD cycle where the handshake completes.
- Arithmetic: no arithmetic in this block; operands and results pass through bit-exact. Width extension and saturation are the MAC's job.
- Reset (asynchronous, also mid-job):
  - State IDLE.
  - instruction=3'b000, multiplier=0, multiplicand=0, stall=1.
  - dot_valid=0, dot_result=0, dot_protect=0.
  - remaining and drain counters cleared, first=0.
  - Any in-flight job is discarded, and no dot_valid follows it.

## Timing
- start is sampled at edge E; busy=1 and op_ready=1 from the cycle after E.
- Pair accepted at edge T: its operands and instruction appear on the MAC ports in cycle T+1, with stall=0 in that cycle only unless another pair is accepted.
- Last pair accepted at T: op_ready=0 from cycle T+1. DRAIN occupies cycles T+1 .. T+1+LATENCY. Capture happens at the end of cycle T+1+LATENCY; dot_valid=1 from cycle T+2+LATENCY.
- Back-to-back pairs sustain one issue per cycle. Gaps in op_valid insert stall=1 cycles and do not change the result.
- len==0: dot_valid=1 in the second cycle after the start edge, with dot_result=0.
- With dot_ready held at 1, dot_valid is high for exactly one cycle. busy drops the cycle after the handshake edge.
- Minimum job-to-job spacing: one IDLE cycle between the HOLD handshake and the next accepted start.

## Test plan
- Basic dot product, LATENCY=4, len=3, pairs (2,3),(4,5),(-1,7) back-to-back:
  - instruction sequence 000,001,001 with stall=0 for 3 cycles.
  - dot_result=32'd19, dot_valid exactly LATENCY+2 cycles after the last accept.
- Same job with op_valid low for 2 cycles between pairs 1 and 2:
  - stall=1 in exactly those gap cycles, instruction held.
  - dot_result=19.
- Backpressure: dot_ready=0 for 5 cycles:
  - dot_valid and dot_result stay stable.
  - start pulses during HOLD are ignored.
  - After dot_ready=1, busy=0 next cycle.
- len=0: dot_valid=1 with dot_result=0 and dot_protect=0; no instruction issued, stall stays 1.
- Extremes: pairs (-32768,-32768) then (-32768,-32768), len=2: dot_result and dot_protect equal the MAC's reported values bit-exact.
- Reset mid-ISSUE after 1 of 3 pairs:
  - All outputs return to reset values immediately.
  - No dot_valid follows.
  - A new len=1 job with pair (3,3) issues instruction 000 and returns 9.
